// File: rtl/mem_port_sequencer.sv
// Shares one byte-wide memory port between the fetch and data requesters.
// Each 32-bit access runs as four big-endian byte beats within one word.
module mem_port_sequencer #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic              if_done,
  output logic [31:0]       if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [31:0]       d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_done,
  output logic [31:0]       d_rdata,
  output logic              if_stall,
  output logic              d_stall,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata
);

  typedef enum logic [2:0] {IDLE, RD, RD_TAIL, WR, DONE} state_t;
  typedef enum logic {FETCH = 1'b0, DATA = 1'b1} requester_t;

  state_t            state;
  state_t            state_next;
  requester_t        grant_q;
  requester_t        last_grant;
  requester_t        grant_sel;
  logic              take;
  logic [1:0]        beat;
  logic [ADDR_W-3:0] base_q;
  logic [31:0]       wdata_q;
  logic [23:0]       asm_q;
  logic              unused_addr_bits;

  // Sub-word and above-memory address bits play no part in the access.
  assign unused_addr_bits = ^{if_addr[31:ADDR_W], if_addr[1:0],
                              d_addr[31:ADDR_W], d_addr[1:0]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Round-robin on a conflict: the requester not served last wins.
  always_comb begin
    state_next = state;
    grant_sel  = FETCH;
    take       = 1'b0;
    if (if_req && d_req) grant_sel = (last_grant == FETCH) ? DATA : FETCH;
    else if (d_req)      grant_sel = DATA;
    case (state)
      IDLE: begin
        if (if_req || d_req) begin
          take       = 1'b1;
          state_next = (grant_sel == DATA && d_we) ? WR : RD;
        end
      end
      RD:      if (beat == 2'd3) state_next = RD_TAIL;
      RD_TAIL: state_next = DONE;
      WR:      if (beat == 2'd3) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant_q    <= FETCH;
      last_grant <= FETCH;
      beat       <= 2'd0;
      base_q     <= '0;
      wdata_q    <= '0;
      asm_q      <= '0;
      if_rdata   <= '0;
      d_rdata    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (take) begin
            grant_q    <= grant_sel;
            last_grant <= grant_sel;
            beat       <= 2'd0;
            base_q     <= (grant_sel == DATA) ? d_addr[ADDR_W-1:2] : if_addr[ADDR_W-1:2];
            if (grant_sel == DATA && d_we) wdata_q <= d_wdata;
          end
        end
        RD: begin
          // Registered memory: the byte for the previous beat arrives now.
          if (beat != 2'd0) asm_q <= {asm_q[15:0], mem_rdata};
          if (beat != 2'd3) beat <= beat + 2'd1;
        end
        RD_TAIL: begin
          if (grant_q == FETCH) if_rdata <= {asm_q, mem_rdata};
          else                  d_rdata  <= {asm_q, mem_rdata};
        end
        WR: begin
          if (beat != 2'd3) beat <= beat + 2'd1;
        end
        default: ;
      endcase
    end
  end

  // The beat counter rests at 3 after an access, so the address holds.
  assign mem_addr = {base_q, beat};
  assign mem_we   = (state == WR);

  always_comb begin
    mem_wdata = wdata_q[31:24];
    case (beat)
      2'd0: mem_wdata = wdata_q[31:24];
      2'd1: mem_wdata = wdata_q[23:16];
      2'd2: mem_wdata = wdata_q[15:8];
      2'd3: mem_wdata = wdata_q[7:0];
      default: mem_wdata = wdata_q[31:24];
    endcase
  end

  assign if_done  = (state == DONE) && (grant_q == FETCH);
  assign d_done   = (state == DONE) && (grant_q == DATA);
  assign if_stall = if_req & ~if_done;
  assign d_stall  = d_req & ~d_done;

endmodule

// File: tb/tb_mem_port_sequencer.sv
// Directed bench for mem_port_sequencer with a byte memory that has registered reads.
// Cycle c is the cycle following rising edge c-1; requests are driven in cycle 0.
module tb_mem_port_sequencer;

  localparam int ADDR_W = 8;

  logic              clk;
  logic              reset;
  logic              if_req;
  logic [31:0]       if_addr;
  logic              if_done;
  logic [31:0]       if_rdata;
  logic              d_req;
  logic              d_we;
  logic [31:0]       d_addr;
  logic [31:0]       d_wdata;
  logic              d_done;
  logic [31:0]       d_rdata;
  logic              if_stall;
  logic              d_stall;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata;

  logic [7:0] mem [0:255];
  int tests_run;
  int tests_failed;

  mem_port_sequencer #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_done(d_done), .d_rdata(d_rdata),
    .if_stall(if_stall), .d_stall(d_stall),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    mem_rdata <= mem[mem_addr];
    if (mem_we) mem[mem_addr] <= mem_wdata;
  end

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    tests_run++;
    if ({mem_we, mem_addr, mem_wdata} !== 17'd0) begin
      tests_failed++;
      $display("[TB] FAIL reset_port: got we=%b addr=%h wdata=%h, want all zero", mem_we, mem_addr, mem_wdata);
    end
    tests_run++;
    if ({if_done, d_done, if_stall, d_stall} !== 4'b0000) begin
      tests_failed++;
      $display("[TB] FAIL reset_done: got %b, want 0000", {if_done, d_done, if_stall, d_stall});
    end
    tests_run++;
    if ({if_rdata, d_rdata} !== 64'd0) begin
      tests_failed++;
      $display("[TB] FAIL reset_rdata: got %h %h, want zero", if_rdata, d_rdata);
    end
    reset = 1'b0;
  endtask

  task automatic test_fetch;
    logic [7:0] exp_addr;
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h10;
    #1;
    tests_run++;
    if (if_stall !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL fetch_stall c=0: got %b, want 1", if_stall);
    end
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      if (c <= 4) begin
        exp_addr = 8'(8'h0F + c);
        tests_run++;
        if (mem_addr !== exp_addr) begin
          tests_failed++;
          $display("[TB] FAIL fetch_addr c=%0d: got %h, want %h", c, mem_addr, exp_addr);
        end
      end
      tests_run++;
      if (if_done !== (c == 6) || mem_we !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL fetch_done c=%0d: got done=%b we=%b, want done=%b we=0", c, if_done, mem_we, (c == 6));
      end
      tests_run++;
      if (if_stall !== (c <= 5)) begin
        tests_failed++;
        $display("[TB] FAIL fetch_stall c=%0d: got %b, want %b", c, if_stall, (c <= 5));
      end
      if (c == 6) begin
        tests_run++;
        if (if_rdata !== 32'h12345678) begin
          tests_failed++;
          $display("[TB] FAIL fetch_rdata: got %h, want 12345678", if_rdata);
        end
        if_req = 1'b0;
      end
    end
  endtask

  task automatic test_store_load;
    logic [31:0] wd;
    logic [7:0]  exp_addr;
    wd = 32'hDEADBEEF;
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h20; d_wdata = wd;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      tests_run++;
      if (mem_we !== (c <= 4)) begin
        tests_failed++;
        $display("[TB] FAIL store_we c=%0d: got %b, want %b", c, mem_we, (c <= 4));
      end
      if (c <= 4) begin
        exp_addr = 8'(8'h1F + c);
        tests_run++;
        if (mem_addr !== exp_addr || mem_wdata !== wd[8*(4-c)+7 -: 8]) begin
          tests_failed++;
          $display("[TB] FAIL store_beat c=%0d: got %h/%h, want %h/%h", c, mem_addr, mem_wdata, exp_addr, wd[8*(4-c)+7 -: 8]);
        end
      end
      tests_run++;
      if (d_done !== (c == 5)) begin
        tests_failed++;
        $display("[TB] FAIL store_done c=%0d: got %b, want %b", c, d_done, (c == 5));
      end
      if (c == 5) begin
        tests_run++;
        if (d_rdata !== 32'd0) begin
          tests_failed++;
          $display("[TB] FAIL store_rdata_hold: got %h, want 00000000", d_rdata);
        end
        d_req = 1'b0;
      end
    end
    tests_run++;
    if ({mem[8'h20], mem[8'h21], mem[8'h22], mem[8'h23]} !== 32'hDEADBEEF) begin
      tests_failed++;
      $display("[TB] FAIL store_mem: got %h%h%h%h, want DEADBEEF", mem[8'h20], mem[8'h21], mem[8'h22], mem[8'h23]);
    end
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h20;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      tests_run++;
      if (d_done !== (c == 6)) begin
        tests_failed++;
        $display("[TB] FAIL load_done c=%0d: got %b, want %b", c, d_done, (c == 6));
      end
      if (c == 6) begin
        tests_run++;
        if (d_rdata !== 32'hDEADBEEF) begin
          tests_failed++;
          $display("[TB] FAIL load_rdata: got %h, want DEADBEEF", d_rdata);
        end
        d_req = 1'b0;
      end
    end
  endtask

  task automatic test_conflict;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    if_req = 1'b1; if_addr = 32'h50;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h30;
    for (int c = 1; c <= 21; c++) begin
      @(negedge clk);
      if (c == 1 || c == 15) begin
        tests_run++;
        if (mem_addr !== 8'h30) begin
          tests_failed++;
          $display("[TB] FAIL conflict_data_grant c=%0d: got %h, want 30", c, mem_addr);
        end
      end
      if (c == 6) begin
        tests_run++;
        if (d_done !== 1'b1 || if_done !== 1'b0 || d_rdata !== 32'hA1A2A3A4) begin
          tests_failed++;
          $display("[TB] FAIL conflict_data_done: got d=%b if=%b rdata=%h, want 1 0 A1A2A3A4", d_done, if_done, d_rdata);
        end
      end
      if (c == 8) begin
        tests_run++;
        if (mem_addr !== 8'h50) begin
          tests_failed++;
          $display("[TB] FAIL conflict_fetch_grant: got %h, want 50", mem_addr);
        end
      end
      if (c == 12) begin
        tests_run++;
        if (if_stall !== 1'b1 || d_stall !== 1'b1) begin
          tests_failed++;
          $display("[TB] FAIL conflict_stall: got if=%b d=%b, want 1 1", if_stall, d_stall);
        end
      end
      if (c == 13) begin
        tests_run++;
        if (if_done !== 1'b1 || if_rdata !== 32'hB1B2B3B4) begin
          tests_failed++;
          $display("[TB] FAIL conflict_fetch_done: got %b %h, want 1 B1B2B3B4", if_done, if_rdata);
        end
        if_req = 1'b0;
      end
      if (c == 20) begin
        tests_run++;
        if (d_done !== 1'b1) begin
          tests_failed++;
          $display("[TB] FAIL conflict_data2_done: got %b, want 1", d_done);
        end
        d_req = 1'b0;
      end
    end
  endtask

  task automatic test_misaligned;
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'hFFFF0013;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (c == 1 || c == 4) begin
        tests_run++;
        if (mem_addr !== 8'(8'h0F + c)) begin
          tests_failed++;
          $display("[TB] FAIL misaligned_addr c=%0d: got %h, want %h", c, mem_addr, 8'(8'h0F + c));
        end
      end
      if (c == 6) begin
        tests_run++;
        if (if_done !== 1'b1 || if_rdata !== 32'h12345678) begin
          tests_failed++;
          $display("[TB] FAIL misaligned_rdata: got %b %h, want 1 12345678", if_done, if_rdata);
        end
        if_req = 1'b0;
      end
    end
  endtask

  task automatic test_reset_mid_store;
    int dones;
    dones = 0;
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'hCAFEF00D;
    repeat (3) @(negedge clk);
    tests_run++;
    if (mem_we !== 1'b1 || mem_addr !== 8'h42) begin
      tests_failed++;
      $display("[TB] FAIL midstore_beat2: got we=%b addr=%h, want 1 42", mem_we, mem_addr);
    end
    reset = 1'b1;
    d_req = 1'b0;
    #1;
    tests_run++;
    if (mem_we !== 1'b0 || mem_addr !== 8'h00 || d_done !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL midstore_reset: got we=%b addr=%h done=%b, want 0 00 0", mem_we, mem_addr, d_done);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (d_done) dones++;
    end
    tests_run++;
    if (dones !== 0) begin
      tests_failed++;
      $display("[TB] FAIL midstore_no_done: got %0d pulses, want 0", dones);
    end
    tests_run++;
    if ({mem[8'h40], mem[8'h41], mem[8'h42], mem[8'h43]} !== 32'hCAFE3344) begin
      tests_failed++;
      $display("[TB] FAIL midstore_mem: got %h%h%h%h, want CAFE3344", mem[8'h40], mem[8'h41], mem[8'h42], mem[8'h43]);
    end
  endtask

  task automatic test_back_to_back;
    int dones;
    dones = 0;
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h20;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (d_done) dones++;
      if (c == 7 || c == 20) begin
        tests_run++;
        if (mem_addr !== 8'h23) begin
          tests_failed++;
          $display("[TB] FAIL b2b_addr_hold c=%0d: got %h, want 23", c, mem_addr);
        end
      end
      if (c == 8) begin
        tests_run++;
        if (mem_addr !== 8'h20) begin
          tests_failed++;
          $display("[TB] FAIL b2b_restart: got %h, want 20", mem_addr);
        end
      end
      if (c == 9) d_req = 1'b0;
      if (c == 13) begin
        tests_run++;
        if (d_done !== 1'b1 || d_rdata !== 32'hDEADBEEF) begin
          tests_failed++;
          $display("[TB] FAIL b2b_done: got %b %h, want 1 DEADBEEF", d_done, d_rdata);
        end
      end
    end
    tests_run++;
    if (dones !== 2) begin
      tests_failed++;
      $display("[TB] FAIL b2b_count: got %0d done pulses, want 2", dones);
    end
  endtask

  initial begin
    clk = 1'b0; reset = 1'b1;
    if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    tests_run = 0; tests_failed = 0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h10] = 8'h12; mem[8'h11] = 8'h34; mem[8'h12] = 8'h56; mem[8'h13] = 8'h78;
    mem[8'h30] = 8'hA1; mem[8'h31] = 8'hA2; mem[8'h32] = 8'hA3; mem[8'h33] = 8'hA4;
    mem[8'h50] = 8'hB1; mem[8'h51] = 8'hB2; mem[8'h52] = 8'hB3; mem[8'h53] = 8'hB4;
    mem[8'h40] = 8'h11; mem[8'h41] = 8'h22; mem[8'h42] = 8'h33; mem[8'h43] = 8'h44;
    test_reset;
    test_fetch;
    test_store_load;
    test_conflict;
    test_misaligned;
    test_reset_mid_store;
    test_back_to_back;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/mem_port_sequencer.md
Name: mem_port_sequencer

Overview:
- Shares the single byte-wide instruction/data memory port between the fetch stage (32-bit word reads) and the memory stage (32-bit loads/stores).
- Arbitrates between the two requesters and sequences each 32-bit access as four byte beats, big-endian.
- Assembles read words and returns them with a one-cycle done pulse; requesters stall on their own req until done.

Parameters:
ADDR_W, 8, byte-address width of the memory port (memory depth 2^ADDR_W bytes)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
if_req  input  1  fetch request; held high, with if_addr stable, until if_done
if_addr  input  32  fetch byte address
if_done  output  1  one-cycle pulse: if_rdata valid
if_rdata  output  32  fetched word
d_req  input  1  data request; held high, with d_we/d_addr/d_wdata stable, until d_done
d_we  input  1  1 = store, 0 = load
d_addr  input  32  data byte address
d_wdata  input  32  store word
d_done  output  1  one-cycle pulse: load data valid or store complete
d_rdata  output  32  loaded word
if_stall  output  1  if_req & ~if_done (combinational)
d_stall  output  1  d_req & ~d_done (combinational)
mem_addr  output  ADDR_W  byte address to memory
mem_we  output  1  byte write enable
mem_wdata  output  8  byte write data
mem_rdata  input  8  registered-read memory data; valid the cycle after mem_addr is driven

Behaviour:
- Reset (async): state IDLE, mem_we=0, mem_addr=0, mem_wdata=0, if_done=d_done=0, if_rdata=d_rdata=0, beat=0, last_grant=FETCH.
- Reset mid-transaction: abandon the transaction immediately, drive mem_we low and enter IDLE; a partial store may leave 0-3 bytes written; no done pulse.
- Address:
  - base = {addr[ADDR_W-1:2], 2'b00]}; addr[1:0] and addr[31:ADDR_W] ignored.
  - Beats never cross a word boundary.
  - Beat k drives mem_addr = base + k, k = 0..3.
- Byte order:
  - beat 0 <-> bits 31:24, beat 1 <-> 23:16, beat 2 <-> 15:8, beat 3 <-> 7:0.
  - Store: mem_wdata = the matching byte of d_wdata.
- FSM states: IDLE, RD, RD_TAIL, WR, DONE.
- IDLE:
  - Samples requests each edge; latches base, op, wdata and the granted requester.
  - Load or fetch -> RD; store -> WR; no request -> stay.
- Arbitration on simultaneous requests: round-robin, granting the requester not in last_grant.
  - First conflict after reset goes to data.
  - last_grant updates on every grant.
- RD:
  - One beat per cycle, beat 0..3, mem_we=0.
  - From the second RD cycle on, capture mem_rdata of the previous beat into the assembly register.
  - After beat 3 -> RD_TAIL.
- RD_TAIL: capture beat-3 byte -> DONE.
- WR: beats 0..3 with mem_we=1 each cycle -> DONE.
- DONE:
  - Assert the granted requester's done for exactly one cycle; the rdata output updates in the same cycle (load/fetch only).
  - d_rdata is unchanged on a store.
  - Requests are not sampled in DONE -> IDLE.
- rdata outputs hold their value until the next completed read for that requester.
- Latency: req sampled at edge 0.
  - Read: addresses in cycles 1-4; done in cycle 6.
  - Write: bytes in cycles 1-4; done in cycle 5.
- Back-to-back: a new grant is sampled at the edge ending the IDLE cycle after DONE.
  - Read occupancy: 7 cycles per access; write: 6.
- Requirement on requesters: req must be low, or carry a new request, by the edge ending the cycle after done.
  - A req still high then is treated as a new request.
- A request dropped before done is a protocol violation; the transaction still completes and done still pulses.
- mem_we is high only in WR.
- mem_addr holds its last value outside RD/WR.

Test Plan:
- Fetch: mem[0x10..0x13]=12,34,56,78; if_req, if_addr=0x10 at edge 0 -> mem_addr 0x10..0x13 in cycles 1-4; if_done=1 in cycle 6 only; if_rdata=0x12345678; if_stall high cycles 0-5.
- Store then load: d_we=1, d_addr=0x20, d_wdata=0xDEADBEEF -> mem_we high cycles 1-4 with bytes DE,AD,BE,EF at 0x20..0x23; d_done in cycle 5; following load from 0x20 -> d_rdata=0xDEADBEEF.
- Conflict: if_req and d_req rise together after reset -> data served first; fetch granted in the IDLE after DONE; next simultaneous pair -> fetch first (round-robin).
- Misaligned/high bits: if_addr=0xFFFF0013, ADDR_W=8 -> reads bytes 0x10..0x13.
- Reset mid-store: assert reset during beat 2 of a store to 0x40 -> mem_we drops immediately, state IDLE, d_done never pulses; mem[0x40],mem[0x41] written, 0x42/0x43 unchanged.
- Held req: d_req kept high for 2 cycles past d_done -> exactly one new transaction starts, sampled in the IDLE cycle.
